// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU operation sequencer:
//   - DATA_W / CNT_W : default operand width and shift repeat-count width
//   - MODE_*         : ALU mode codes (same encoding as the team ALU)
//   - state_t        : sequencer FSM states
//   - is_shift_mode  : true for the single-bit shift modes that get iterated
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  localparam logic [3:0] MODE_LSL   = 4'd0;
  localparam logic [3:0] MODE_ASL   = 4'd1;
  localparam logic [3:0] MODE_LSR   = 4'd2;
  localparam logic [3:0] MODE_ASR   = 4'd3;
  localparam logic [3:0] MODE_ADD   = 4'd4;
  localparam logic [3:0] MODE_SUB   = 4'd5;
  localparam logic [3:0] MODE_AND   = 4'd6;
  localparam logic [3:0] MODE_OR    = 4'd7;
  localparam logic [3:0] MODE_XOR   = 4'd8;
  localparam logic [3:0] MODE_NOT   = 4'd9;
  localparam logic [3:0] MODE_INC   = 4'd10;
  localparam logic [3:0] MODE_DEC   = 4'd11;
  localparam logic [3:0] MODE_PASSA = 4'd12;
  localparam logic [3:0] MODE_PASSB = 4'd13;
  localparam logic [3:0] MODE_CLZ   = 4'd14;
  localparam logic [3:0] MODE_FFO   = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Modes 0-3 are the 1-bit shifts that the sequencer repeats req_count times.
  function automatic logic is_shift_mode(input logic [3:0] mode);
    return (mode <= MODE_ASR);
  endfunction

endpackage

// File: rtl/alu_seq_stats.sv
// -----------------------------------------------------------------------------
// alu_seq_stats
// Saturating statistics counters for the ALU sequencer (only instantiated when
// ALU_SEQ_STATS_EN is defined).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (counters clear)
//   i_hs        : response handshake this cycle
//   i_ovf       : the response being handed over has overflow set
//   o_stat_ops  : completed responses, saturating at 16'hFFFF
//   o_stat_ovf  : completed responses with overflow, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module alu_seq_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hs,
  input  logic        i_ovf,
  output logic [15:0] o_stat_ops,
  output logic [15:0] o_stat_ovf
);

  localparam logic [15:0] SAT_VAL = 16'hFFFF;

  // Count handshakes and overflowing handshakes, holding at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stat_ops <= 16'h0000;
      o_stat_ovf <= 16'h0000;
    end else begin
      if (i_hs && (o_stat_ops != SAT_VAL)) begin
        o_stat_ops <= o_stat_ops + 16'h0001;
      end else begin
        o_stat_ops <= o_stat_ops;
      end
      if (i_hs && i_ovf && (o_stat_ovf != SAT_VAL)) begin
        o_stat_ovf <= o_stat_ovf + 16'h0001;
      end else begin
        o_stat_ovf <= o_stat_ovf;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Registered initiator for the team's 16-bit combinational ALU. A request is
// accepted on a valid/ready channel, driven to the ALU from registers, and the
// result is returned on a valid/ready response channel. The 1-bit shift modes
// (0-3) are repeated req_count times by feeding Y back into A.
// Optional feature: define ALU_SEQ_STATS_EN to add stat_ops / stat_ovf.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   req_valid/req_ready                : request handshake
//   req_mode/a/b/cin/count             : operation request
//   alu_mode/a/b/cin                   : registered drive to the ALU
//   alu_y/cout/overflow                : ALU result inputs
//   rsp_valid/rsp_ready                : response handshake
//   rsp_y/cout/overflow/zero           : registered response
//   busy                               : FSM not idle
//   stat_ops/stat_ovf (optional)       : saturating response statistics
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_mode,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_cin,
  input  logic [CNT_W-1:0]  req_count,
  output logic [3:0]        alu_mode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_cout,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_cout,
  output logic              rsp_overflow,
  output logic              rsp_zero,
  output logic              busy
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_ovf
`endif
);

  import alu_seq_pkg::*;

  state_t              r_state;
  logic [3:0]          r_op_mode;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic                r_op_cin;
  logic [CNT_W-1:0]    r_remaining;
  logic                r_ovf;
  logic                r_req_ready;
  logic                r_busy;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_y;
  logic                r_rsp_cout;
  logic                r_rsp_ovf;
  logic                r_rsp_zero;

  logic [CNT_W-1:0]    w_iter_n;
  logic                w_accept;
  logic                w_rsp_hs;
  logic                w_ovf_acc;

  // Non-shift modes always take exactly one ALU pass; req_count is ignored.
  assign w_iter_n  = is_shift_mode(req_mode) ? req_count : CNT_W'(1);
  assign w_accept  = req_valid && r_req_ready;
  assign w_rsp_hs  = r_rsp_valid && rsp_ready;
  // Overflow is sticky across shift iterations.
  assign w_ovf_acc = r_ovf | alu_overflow;

  // Sequencer FSM: accept, iterate the ALU, then hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op_mode   <= 4'd0;
      r_op_a      <= {DATA_W{1'b0}};
      r_op_b      <= {DATA_W{1'b0}};
      r_op_cin    <= 1'b0;
      r_remaining <= {CNT_W{1'b0}};
      r_ovf       <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_y     <= {DATA_W{1'b0}};
      r_rsp_cout  <= 1'b0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_mode   <= req_mode;
            r_op_a      <= req_a;
            r_op_b      <= req_b;
            r_op_cin    <= req_cin;
            r_ovf       <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_iter_n == {CNT_W{1'b0}}) begin
              // Zero-length shift: A is returned untouched, ALU not consulted.
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_y     <= req_a;
              r_rsp_cout  <= 1'b0;
              r_rsp_ovf   <= 1'b0;
              r_rsp_zero  <= (req_a == {DATA_W{1'b0}});
            end else begin
              r_state     <= RUN;
              r_remaining <= w_iter_n;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_op_a      <= alu_y;
          r_ovf       <= w_ovf_acc;
          r_remaining <= r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1)) begin
            // Last pass: capture this ALU result straight into the response.
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_y     <= alu_y;
            r_rsp_cout  <= alu_cout;
            r_rsp_ovf   <= w_ovf_acc;
            r_rsp_zero  <= (alu_y == {DATA_W{1'b0}});
          end else begin
            r_state <= RUN;
          end
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
          end else begin
            r_state <= RESP;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign busy         = r_busy;
  assign alu_mode     = r_op_mode;
  assign alu_a        = r_op_a;
  assign alu_b        = r_op_b;
  assign alu_cin      = r_op_cin;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_y        = r_rsp_y;
  assign rsp_cout     = r_rsp_cout;
  assign rsp_overflow = r_rsp_ovf;
  assign rsp_zero     = r_rsp_zero;

`ifdef ALU_SEQ_STATS_EN
  alu_seq_stats u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hs       (w_rsp_hs),
    .i_ovf      (r_rsp_ovf),
    .o_stat_ops (stat_ops),
    .o_stat_ovf (stat_ovf)
  );
`else
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Registered initiator that drives the team's 16-bit combinational ALU.
- Accepts operation requests on a valid/ready channel and drives Mode/A/B/Cin to the ALU.
- Captures Y/Cout/Overflow and returns them, with a zero flag, on a valid/ready response channel.
- The ALU shifts only by 1 bit, so shift modes 0-3 are iterated over multiple cycles by feeding Y back into A. This gives multi-bit shifts without changing the ALU.

Parameters:
- DATA_W, 16: operand/result width; must match the ALU.
- CNT_W, 4: width of the shift repeat count (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_mode  in  4  ALU mode code (0..15, same encoding as the ALU).
- req_a  in  DATA_W  operand A.
- req_b  in  DATA_W  operand B.
- req_cin  in  1  carry in.
- req_count  in  CNT_W  shift repeat count; used only for modes 0-3.
- alu_mode  out  4  to ALU Mode.
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_cin  out  1  to ALU Cin.
- alu_y  in  DATA_W  from ALU Y.
- alu_cout  in  1  from ALU Cout.
- alu_overflow  in  1  from ALU Overflow.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer takes the result.
- rsp_y  out  DATA_W  result.
- rsp_cout  out  1  carry out.
- rsp_overflow  out  1  overflow.
- rsp_zero  out  1  rsp_y == 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; all operand/result registers clear to 0.
  - Outputs: req_ready=1 once out of reset, rsp_valid=0, rsp_y=0, rsp_cout=0, rsp_overflow=0, rsp_zero=0, busy=0, alu_mode/a/b/cin=0.
  - Reset mid-operation abandons the operation and produces no response.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch mode/a/b/cin into op registers.
  - Iteration count N = req_count for modes 0-3, N = 1 for all other modes.
  - N==0: go to RESP with rsp_y=req_a, cout=0, overflow=0; the ALU result is not used.
  - N>=1: go to RUN with remaining=N.
- RUN:
  - alu_* driven directly from the op registers (glitch-free, registered).
  - Each edge: op_a <= alu_y, cout_r <= alu_cout, ovf_r <= ovf_r | alu_overflow, remaining decrements.
  - Overflow is sticky across shift iterations; Cout comes from the last iteration only.
  - When remaining reaches 1 on an edge, that edge also moves the state to RESP.
- RESP:
  - rsp_valid=1; rsp_* hold steady until rsp_ready.
  - On rsp_valid&&rsp_ready: return to IDLE.
  - req_ready=0 throughout RUN and RESP; there is no request overlap.
- Latency: counting the acceptance cycle as cycle 0, rsp_valid is first high in cycle N+1 (cycle 1 for N=0, cycle 2 for non-shift modes).
- Backpressure: rsp_ready may stay low indefinitely; outputs do not change and no new request is accepted.
- rsp_zero is computed from the registered rsp_y.
- req_count is ignored for modes 4-15; wrap-around is impossible because the count is at most 15.
- Throughput: one request per N+2 cycles minimum.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- Defined:
  - Adds outputs stat_ops (16 bits), counting completed response handshakes.
  - Adds stat_ovf (16 bits), counting completed responses with rsp_overflow=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent, and the core behaviour is identical.

Decomposition:
- Shared package alu_seq_pkg:
  - DATA_W and CNT_W constants.
  - Mode code localparams: MODE_LSL=0, MODE_ASL=1, MODE_LSR=2, MODE_ASR=3, MODE_ADD=4, MODE_SUB=5 … MODE_FFO=15.
  - State enum {IDLE, RUN, RESP}.
- One natural sub-module, alu_seq_stats: the saturating counter pair, instantiated only under ALU_SEQ_STATS_EN.
- The ALU itself is instantiated next to the sequencer in the bench/top, not inside it.

Test Plan:
- All scenarios run against the team ALU; where modes 1-3 are incomplete, the bench uses a behavioural ALU model in which ASL overflow means the sign bit changed.
- Add: mode 4, A=16'h7FFF, B=16'h0001, cin=0 -> rsp_y=16'h8000, overflow=1, cout=0, zero=0, rsp_valid in cycle 2.
- Multi-shift: mode 0, A=16'h00F1, count=4 -> rsp_y=16'h0F10, rsp_valid in cycle 5, busy high cycles 1-5.
- Arithmetic right shift: mode 3, A=16'h8000, count=3 -> rsp_y=16'hF000. Arithmetic left shift: mode 1, A=16'h4000, count=2 -> rsp_y=16'h0000, overflow=1 (sticky), zero=1.
- Zero count: mode 2, A=16'h1234, count=0 -> rsp_y=16'h1234, cout=0, overflow=0, rsp_valid in cycle 1.
- Backpressure: hold rsp_ready=0 for 5 cycles after a sub of 5-3 -> rsp_y=16'h0002 stable, req_ready=0, a second req_valid is not accepted until after the handshake.
- Reset: assert rst_n=0 during RUN of a count=10 shift -> immediate IDLE, rsp_valid=0, all outputs 0, and no response after release.
